// File: rtl/apb4_cpuif_initiator.sv
// Valid/ready command stream to APB4 initiator, one transfer in flight, strictly in order.
// Optional ACCESS-phase watchdog and timeout_sticky port enabled by defining CPUIF_INIT_TIMEOUT_EN.
module apb4_cpuif_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
`ifdef CPUIF_INIT_TIMEOUT_EN
    output logic                    timeout_sticky,
`endif
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
    output logic [2:0]              m_apb_pprot,
    input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
    input  logic                    m_apb_pready,
    input  logic                    m_apb_pslverr
);

    // state  | meaning
    // IDLE   | req_ready high, waiting for a command
    // SETUP  | APB setup phase (psel=1, penable=0), one cycle
    // ACCESS | APB access phase, waiting for pready
    // RESP   | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)
        || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb4_cpuif_initiator: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;
`ifdef CPUIF_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
`ifdef CPUIF_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pwrite_d    = req_write;
                    paddr_d     = req_addr & ADDR_MASK;
                    pwdata_d    = req_wdata;
                    pstrb_d     = req_write ? req_wstrb : '0;
                    psel_d      = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef CPUIF_INIT_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (m_apb_pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : m_apb_prdata;
                    rsp_error_d = m_apb_pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef CPUIF_INIT_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        rsp_rdata_d = '0;
                        rsp_error_d = 1'b1;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        sticky_d    = 1'b1;
                        state_d     = RESP;
                    end
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
`ifdef CPUIF_INIT_TIMEOUT_EN
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
`ifdef CPUIF_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_error     = rsp_error_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;
    assign m_apb_pprot   = 3'b000;
`ifdef CPUIF_INIT_TIMEOUT_EN
    assign timeout_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_apb4_cpuif_initiator.sv
// Bench for apb4_cpuif_initiator: vector table plus scoreboard of expected responses.
// Timeout sequence is compiled in only when CPUIF_INIT_TIMEOUT_EN is defined.
module tb_apb4_cpuif_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
`ifdef CPUIF_INIT_TIMEOUT_EN
    logic        timeout_sticky;
`endif

    always #5 clk = ~clk;

    apb4_cpuif_initiator #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
`ifdef CPUIF_INIT_TIMEOUT_EN
        .timeout_sticky(timeout_sticky),
`endif
        .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
        .m_apb_paddr(paddr), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
        .m_apb_pprot(pprot), .m_apb_prdata(prdata),
        .m_apb_pready(pready), .m_apb_pslverr(pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        junk_err;
        int          rsp_delay;
        logic        hold_valid;
        logic [31:0] exp_paddr;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[8];
    logic [32:0] sb[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered just after a negedge; returns just after a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        int          c;
        bit          got;
        logic [32:0] exp;
        req_valid = 1'b1;
        req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        sb.push_back({v.exp_rdata, v.exp_err});
        @(negedge clk);
        c = 1;
        if (!v.hold_valid) req_valid = 1'b0;
        chk("setup_phase", {psel, penable, pwrite, paddr, pstrb, pwdata, req_ready},
            {1'b1, 1'b0, v.write, v.exp_paddr, v.exp_pstrb, v.wdata, 1'b0});
        pready = 1'b0;
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            chk("access_phase", {psel, penable, pwrite, paddr, pstrb, pwdata, req_ready, rsp_valid},
                {1'b1, 1'b1, v.write, v.exp_paddr, v.exp_pstrb, v.wdata, 1'b0, 1'b0});
            pready  = (k == v.waits);
            pslverr = (k == v.waits) ? v.slverr : v.junk_err;
            prdata  = (k == v.waits) ? v.prdata : ~v.prdata;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_0BAD;
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_latency", got ? c : 0, 3 + v.waits);
        if (!got) begin
            do_reset();
            sb.delete();
            return;
        end
        for (int d = 0; d <= v.rsp_delay; d++) begin
            if (d > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("resp_hold", {rsp_valid, req_ready, psel, penable, rsp_rdata, rsp_error},
                {1'b1, 1'b0, 1'b0, 1'b0, v.exp_rdata, v.exp_err});
        end
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            exp = sb.pop_front();
            chk("rsp_data", {rsp_rdata, rsp_error}, exp);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("back_to_idle", {rsp_valid, req_ready, psel}, {1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        //          wr    addr          wdata         strb  w  prdata        slv   junk  dly hold exp_paddr     pstrb exp_rdata     err
        vecs[0] = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 0, 32'h1111_1111, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0014, 4'hF, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 3, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0008, 4'h0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 2, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 2, 32'hAAAA_5555, 1'b0, 1'b1, 1, 1'b0, 32'h0000_0030, 4'h0, 32'hAAAA_5555, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0103, 32'h0102_0304, 4'h5, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 1'b0, 32'h0000_0100, 4'h5, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h0000_0007, 32'h5A5A_5A5A, 4'hF, 0, 32'h7654_3210, 1'b0, 1'b0, 5, 1'b1, 32'h0000_0004, 4'h0, 32'h7654_3210, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFE, 32'h8000_0001, 4'h8, 1, 32'h0,         1'b0, 1'b0, 0, 1'b0, 32'hFFFF_FFFC, 4'h8, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0000, 4'h0, 32'h0F0F_0F0F, 1'b0};

        do_reset();
        chk("reset_state", {req_ready, rsp_valid, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_rdata, rsp_error},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0});
`ifdef CPUIF_INIT_TIMEOUT_EN
        chk("sticky_reset", timeout_sticky, 1'b0);
`endif

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        chk("sb_drained", sb.size(), 0);

        // Reset while the transfer sits in ACCESS with pready low.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wstrb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset", {psel, penable, rsp_valid, req_ready}, 4'b0001);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_rsp_after_reset", {rsp_valid, psel}, 2'b00);
        end
        run_vec(vecs[1]);

`ifdef CPUIF_INIT_TIMEOUT_EN
        begin
            int c;
            bit got;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_wstrb = 4'h0;
            pready = 1'b0; prdata = 32'hFFFF_0000;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            c = 1;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk);
                @(negedge clk);
                c++;
                if (rsp_valid) got = 1'b1;
            end
            chk("timeout_latency", got ? c : 0, 6);
            chk("timeout_rsp", {psel, penable, rsp_rdata, rsp_error, timeout_sticky},
                {1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("sticky_holds", {timeout_sticky, req_ready}, 2'b11);
            do_reset();
            chk("sticky_cleared", timeout_sticky, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
